// File: rtl/case_7_prod_acc_10s_12.sv
// Frame accumulator for the case_7 signed product stream.
// Sums up to ACC_LEN beats per frame and presents one saturated result per frame.
module case_7_prod_acc_10s_12 #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_LEN   = 16,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 12,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [DIN_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] LP_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  // ~max equals -max-1, the most negative representable result
  localparam logic signed [ACC_WIDTH-1:0] LP_MIN = ~LP_MAX;
  localparam logic [CNT_WIDTH-1:0]        LP_LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);

  state_t                        r_state;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic        [CNT_WIDTH-1:0]   r_cnt;
  logic        [OUT_WIDTH-1:0]   r_out_data;
  logic        [CNT_WIDTH-1:0]   r_out_count;
  logic                          r_out_sat;

  state_t                        w_state_next;
  logic signed [ACC_WIDTH-1:0]   w_acc_next;
  logic        [CNT_WIDTH-1:0]   w_cnt_next;
  logic        [OUT_WIDTH-1:0]   w_out_data_next;
  logic        [CNT_WIDTH-1:0]   w_out_count_next;
  logic                          w_out_sat_next;

  logic signed [ACC_WIDTH-1:0]   w_din_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;
  logic        [CNT_WIDTH-1:0]   w_cnt_inc;
  logic                          w_accept;
  logic                          w_close;
  logic        [OUT_WIDTH-1:0]   w_sat_data;
  logic                          w_clip;

  assign w_din_ext = {{(ACC_WIDTH - DIN_WIDTH){in_data[DIN_WIDTH-1]}}, in_data};
  assign w_sum     = r_acc + w_din_ext;
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_accept  = in_valid && (r_state == S_ACCUM);
  // in_last on the final allowed beat is the same single close event
  assign w_close   = w_accept && (in_last || (r_cnt == LP_LAST_CNT));

  always_comb begin
    w_sat_data = w_sum[OUT_WIDTH-1:0];
    w_clip     = 1'b0;
    if (w_sum > LP_MAX) begin
      w_sat_data = LP_MAX[OUT_WIDTH-1:0];
      w_clip     = 1'b1;
    end else if (w_sum < LP_MIN) begin
      w_sat_data = LP_MIN[OUT_WIDTH-1:0];
      w_clip     = 1'b1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_cnt_next       = r_cnt;
    w_out_data_next  = r_out_data;
    w_out_count_next = r_out_count;
    w_out_sat_next   = r_out_sat;
    case (r_state)
      S_ACCUM: begin
        if (w_close) begin
          w_out_data_next  = w_sat_data;
          w_out_sat_next   = w_clip;
          w_out_count_next = w_cnt_inc;
          w_acc_next       = '0;
          w_cnt_next       = '0;
          w_state_next     = S_HOLD;
        end else if (w_accept) begin
          w_acc_next = w_sum;
          w_cnt_next = w_cnt_inc;
        end
      end
      S_HOLD: begin
        // Result stays frozen; returning to ACCUM costs one bubble cycle
        if (out_ready) begin
          w_state_next = S_ACCUM;
        end
      end
      default: begin
        w_state_next = S_ACCUM;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_cnt       <= w_cnt_next;
      r_out_data  <= w_out_data_next;
      r_out_count <= w_out_count_next;
      r_out_sat   <= w_out_sat_next;
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_case_7_prod_acc_10s_12.sv
// Scoreboard bench for case_7_prod_acc_10s_12: a cycle model tracks beats and handshake
// state on the falling edge; expected frame results are queued and compared while held.
module tb_case_7_prod_acc_10s_12;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [11:0] out_data;
  logic [4:0]  out_count;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  case_7_prod_acc_10s_12 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int data;
    int count;
    int sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_frames = 0;
  int   m_acc    = 0;
  int   m_cnt    = 0;
  bit   m_hold   = 1'b0;
  bit   rand_or  = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model, evaluated on the falling edge where inputs and outputs are stable
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      sb_q.delete();
      m_acc  = 0;
      m_cnt  = 0;
      m_hold = 1'b0;
    end else begin
      check_val("in_ready", int'(in_ready), int'(!m_hold));
      check_val("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          check_val("out_data", int'($signed(out_data)), sb_q[0].data);
          check_val("out_count", int'(out_count), sb_q[0].count);
          check_val("out_sat", int'(out_sat), sb_q[0].sat);
          if (out_ready) begin
            $display("frame %0d: data=%0d count=%0d sat=%0d", n_frames,
                     $signed(out_data), out_count, out_sat);
            n_frames++;
            void'(sb_q.pop_front());
            m_hold = 1'b0;
          end
        end
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        int   sum;
        exp_t e;
        sum   = m_acc + int'($signed(in_data));
        m_cnt = m_cnt + 1;
        if (in_last || m_cnt == 16) begin
          e.count = m_cnt;
          e.sat   = (sum > 2047 || sum < -2048) ? 1 : 0;
          e.data  = (sum > 2047) ? 2047 : ((sum < -2048) ? -2048 : sum);
          sb_q.push_back(e);
          m_acc  = 0;
          m_cnt  = 0;
          m_hold = 1'b1;
        end else begin
          m_acc = sum;
        end
      end
    end
  end

  always @(posedge ap_clk) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic beat(input int d, input bit last);
    bit took;
    int n;
    took     = 1'b0;
    n        = 0;
    in_valid = 1'b1;
    in_data  = 10'(d);
    in_last  = last;
    do begin
      @(negedge ap_clk);
      took = in_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!took && n < 300);
    if (!took) check_val("beat_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, int'(out_valid), 0);
    check_val({tag, "_out_data"}, int'(out_data), 0);
    check_val({tag, "_out_count"}, int'(out_count), 0);
    check_val({tag, "_out_sat"}, int'(out_sat), 0);
    check_val({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int n;
    ap_rst_n  = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step(3);
    check_reset_outputs("rst");
    ap_rst_n = 1'b1;
    step(2);

    // T1 / T2: full-length saturating frames
    for (int i = 0; i < 16; i++) beat(511, 1'b0);
    step(3);
    for (int i = 0; i < 16; i++) beat(-512, 1'b0);
    step(3);

    // T3: in_last-terminated frame, then a 1-beat frame from a clean accumulator
    beat(100, 1'b0);
    beat(-200, 1'b0);
    beat(50, 1'b1);
    step(2);
    beat(1, 1'b1);
    step(2);

    // T4: consumer stalls while the producer keeps pushing
    out_ready = 1'b0;
    beat(10, 1'b0);
    beat(20, 1'b1);
    in_valid = 1'b1;
    in_data  = 10'd7;
    step(5);
    out_ready = 1'b1;
    step(2);
    in_valid = 1'b0;
    beat(3, 1'b1);
    step(2);

    // T5: reset mid-frame
    for (int i = 0; i < 7; i++) beat(i + 1, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("t5rst");
    step(2);
    check_reset_outputs("t5rst2");
    ap_rst_n = 1'b1;
    step(1);
    beat(5, 1'b0);
    beat(6, 1'b1);
    check_val("t5_valid", int'(out_valid), 1);
    check_val("t5_data", int'($signed(out_data)), 11);
    check_val("t5_count", int'(out_count), 2);
    step(2);

    // T6: random traffic
    rand_or = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        step($urandom_range(0, 2));
        beat(int'($urandom_range(0, 1023)) - 512, b == len - 1);
      end
    end
    rand_or   = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((m_hold || sb_q.size() != 0) && n < 100) begin
      step(1);
      n++;
    end
    check_val("drain_pending", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
